// File: rtl/date_edit_pkg.sv
// Shared encodings, default timing constants and helpers for the
// calendar front-panel edit controller.
package date_edit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DAY   = 2'd1,
        ST_MONTH = 2'd2,
        ST_YEAR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RPT_NONE = 2'd0,
        RPT_UP   = 2'd1,
        RPT_DOWN = 2'd2
    } rpt_t;

    localparam int DEF_DEB_CYCLES    = 1_000_000;
    localparam int DEF_REPEAT_DELAY  = 50_000_000;
    localparam int DEF_REPEAT_PERIOD = 15_000_000;
    localparam int DEF_EDIT_TIMEOUT  = 1_000_000_000;

    function automatic int max_int(input int a, input int b);
        int r;
        r = (a > b) ? a : b;
        return r;
    endfunction

    function automatic state_t next_field(input state_t s);
        state_t r;
        unique case (s)
            ST_IDLE:  r = ST_DAY;
            ST_DAY:   r = ST_MONTH;
            ST_MONTH: r = ST_YEAR;
            default:  r = ST_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/date_edit_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one push-button;
// press marks the rising edge of the debounced level.
module btn_debounce
    import date_edit_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            meta    <= raw;
            sync    <= meta;
            level_d <= level;
            // any cycle that agrees with the accepted level restarts the count
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/date_edit_ctrl.sv
// Edit controller for the day/month/year counters: SET walks the fields,
// UP/DOWN give single-cycle pulses with auto-repeat, idle edits time out.
module date_edit_ctrl
    import date_edit_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int EDIT_TIMEOUT  = DEF_EDIT_TIMEOUT
) (
    input  logic Clock,
    input  logic Reset,
    input  logic btn_set,
    input  logic btn_up,
    input  logic btn_down,
    output logic en_day,
    output logic en_month,
    output logic en_year,
    output logic up,
    output logic down,
    output logic editing
);

    localparam int TW = $clog2(EDIT_TIMEOUT + 1);
    localparam int RW =
        $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [TW-1:0] TMO_LAST = TW'(EDIT_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(EDIT_TIMEOUT);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RPT_MAX  = '1;

    logic set_lvl, set_p;
    logic up_lvl, up_p;
    logic dn_lvl, dn_p;
    logic any_p;

    state_t        state, state_nx;
    logic [TW-1:0] tmo, tmo_nx;
    rpt_t          rdir, rdir_nx;
    logic [RW-1:0] rcnt, rcnt_nx;
    logic          rfirst, rfirst_nx;
    logic          rpt_hit;
    logic          up_nx, down_nx;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set (
        .Clock (Clock),
        .Reset (Reset),
        .raw   (btn_set),
        .level (set_lvl),
        .press (set_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
        .Clock (Clock),
        .Reset (Reset),
        .raw   (btn_up),
        .level (up_lvl),
        .press (up_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down (
        .Clock (Clock),
        .Reset (Reset),
        .raw   (btn_down),
        .level (dn_lvl),
        .press (dn_p)
    );

    assign any_p = set_p | up_p | dn_p;

    always_comb begin
        state_nx = state;
        if (set_p) begin
            state_nx = next_field(state);
        end else if (state != ST_IDLE && !any_p &&
                     tmo == TMO_LAST) begin
            state_nx = ST_IDLE;
        end
    end

    always_comb begin
        tmo_nx = tmo;
        if (state_nx == ST_IDLE || state_nx != state || any_p) begin
            tmo_nx = '0;
        end else if (tmo != TMO_MAX) begin
            tmo_nx = tmo + 1'b1;
        end
    end

    always_comb begin
        up_nx     = 1'b0;
        down_nx   = 1'b0;
        rdir_nx   = rdir;
        rcnt_nx   = rcnt;
        rfirst_nx = rfirst;
        rpt_hit   = rfirst ? (rcnt == DLY_LAST) : (rcnt == PER_LAST);
        // field changes and chorded UP+DOWN kill any pulse and the repeat
        if (state == ST_IDLE || state_nx != state ||
            (up_lvl && dn_lvl)) begin
            rdir_nx = RPT_NONE;
        end else if (up_p) begin
            up_nx     = 1'b1;
            rdir_nx   = RPT_UP;
            rcnt_nx   = '0;
            rfirst_nx = 1'b1;
        end else if (dn_p) begin
            down_nx   = 1'b1;
            rdir_nx   = RPT_DOWN;
            rcnt_nx   = '0;
            rfirst_nx = 1'b1;
        end else if (set_lvl) begin
            rdir_nx = RPT_NONE;
        end else if ((rdir == RPT_UP && !up_lvl) ||
                     (rdir == RPT_DOWN && !dn_lvl)) begin
            rdir_nx = RPT_NONE;
        end else if (rdir != RPT_NONE) begin
            if (rpt_hit) begin
                up_nx     = (rdir == RPT_UP);
                down_nx   = (rdir == RPT_DOWN);
                rcnt_nx   = '0;
                rfirst_nx = 1'b0;
            end else if (rcnt != RPT_MAX) begin
                rcnt_nx = rcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            tmo      <= '0;
            rdir     <= RPT_NONE;
            rcnt     <= '0;
            rfirst   <= 1'b0;
            up       <= 1'b0;
            down     <= 1'b0;
            en_day   <= 1'b0;
            en_month <= 1'b0;
            en_year  <= 1'b0;
            editing  <= 1'b0;
        end else begin
            state    <= state_nx;
            tmo      <= tmo_nx;
            rdir     <= rdir_nx;
            rcnt     <= rcnt_nx;
            rfirst   <= rfirst_nx;
            up       <= up_nx;
            down     <= down_nx;
            en_day   <= (state_nx == ST_DAY);
            en_month <= (state_nx == ST_MONTH);
            en_year  <= (state_nx == ST_YEAR);
            editing  <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_date_edit_ctrl.sv
// Directed bench for date_edit_ctrl: expected pulse and field events are
// queued when buttons are driven and checked every cycle.
module tb_date_edit_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int TMO = 100;
    // raw edge -> 2 sync + DEB stable -> registered output
    localparam int LAT = 2 + DEB + 1;

    localparam int K_UP  = 0;
    localparam int K_DN  = 1;
    localparam int K_ST  = 2;
    localparam int K_ACT = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [1:0] st;
    } ev_t;

    logic Clock = 1'b0;
    logic Reset;
    logic btn_set, btn_up, btn_down;
    logic en_day, en_month, en_year;
    logic up, down, editing;

    ev_t        q[$];
    int         cyc      = 0;
    int         vecs     = 0;
    int         fails    = 0;
    int         last_act = 0;
    logic [1:0] cur_st   = 2'd0;
    logic [1:0] plan_st  = 2'd0;

    always #5 Clock = ~Clock;

    date_edit_ctrl #(
        .DEB_CYCLES    (DEB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .EDIT_TIMEOUT  (TMO)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .btn_set  (btn_set),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .en_day   (en_day),
        .en_month (en_month),
        .en_year  (en_year),
        .up       (up),
        .down     (down),
        .editing  (editing)
    );

    function automatic logic [3:0] enc(input logic [1:0] s);
        logic [3:0] r;
        case (s)
            2'd1:    r = 4'b1001;
            2'd2:    r = 4'b0101;
            2'd3:    r = 4'b0011;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    task automatic check(input logic [3:0] obs,
                         input logic [3:0] exp,
                         input string tag);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int c, input int k, input logic [1:0] s);
        ev_t e;
        int  i;
        e.cyc  = c;
        e.kind = k;
        e.st   = s;
        i = 0;
        while (i < q.size() && q[i].cyc <= c) i++;
        q.insert(i, e);
    endtask

    task automatic tick();
        logic eu, ed;
        ev_t  e;
        @(posedge Clock);
        #1;
        cyc++;
        eu = 1'b0;
        ed = 1'b0;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.kind)
                K_UP: eu = 1'b1;
                K_DN: ed = 1'b1;
                K_ST: begin
                    cur_st   = e.st;
                    last_act = cyc;
                end
                default: last_act = cyc;
            endcase
        end
        if (cur_st != 2'd0 && cyc == last_act + TMO) cur_st = 2'd0;
        check({3'b0, up}, {3'b0, eu}, "up");
        check({3'b0, down}, {3'b0, ed}, "down");
        check({en_day, en_month, en_year, editing}, enc(cur_st),
              "fields");
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press_set(input int n);
        int d;
        d = cyc;
        btn_set = 1'b1;
        plan_st = plan_st + 2'd1;
        push(d + LAT, K_ST, plan_st);
        repeat (n) tick();
        btn_set = 1'b0;
    endtask

    // debounced level stays high through cycle d+n+1+DEB, so the last
    // repeat pulse can register one cycle later
    task automatic hold(input logic u, input logic dn,
                        input int n, input bit pulses);
        int d, k;
        d = cyc;
        btn_up   = u;
        btn_down = dn;
        push(d + LAT, K_ACT, 2'd0);
        if (pulses && (u != dn)) begin
            k = u ? K_UP : K_DN;
            push(d + LAT, k, 2'd0);
            for (int p = d + LAT + RD; p <= d + n + 2 + DEB; p += RP)
                push(p, k, 2'd0);
        end
        repeat (n) tick();
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    initial begin
        int d, ent;
        Reset    = 1'b1;
        btn_set  = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        idle(2);
        Reset = 1'b0;
        idle(3);

        // UP in IDLE is ignored
        hold(1'b1, 1'b0, 8, 1'b0);
        idle(10);

        // bounced SET, then timeout 100 cycles after entry
        btn_set = 1'b1;
        tick();
        btn_set = 1'b0;
        tick();
        press_set(11);
        idle(110);
        plan_st = 2'd0;

        // a press at cycle 90 restarts the timeout
        d = cyc;
        press_set(6);
        ent = d + LAT;
        while (cyc < ent + 90 - LAT) tick();
        hold(1'b1, 1'b0, 8, 1'b1);
        idle(110);
        plan_st = 2'd0;

        // DAY: chorded UP+DOWN gives nothing
        press_set(6);
        idle(8);
        hold(1'b1, 1'b1, 40, 1'b1);
        idle(8);

        // MONTH: held DOWN auto-repeats
        press_set(6);
        idle(8);
        hold(1'b0, 1'b1, 60, 1'b1);
        idle(8);

        // YEAR: short UP press, then back to IDLE
        press_set(6);
        idle(8);
        hold(1'b1, 1'b0, 8, 1'b1);
        idle(8);
        press_set(6);
        idle(8);

        // SET while UP held cancels the repeat
        press_set(6);
        idle(8);
        d = cyc;
        btn_up = 1'b1;
        push(d + LAT, K_ACT, 2'd0);
        push(d + LAT, K_UP, 2'd0);
        idle(10);
        press_set(6);
        idle(24);
        btn_up = 1'b0;
        idle(10);

        // reset in the middle of an auto-repeat
        d = cyc;
        btn_up = 1'b1;
        push(d + LAT, K_ACT, 2'd0);
        push(d + LAT, K_UP, 2'd0);
        push(d + LAT + RD, K_UP, 2'd0);
        push(d + LAT + RD + RP, K_UP, 2'd0);
        idle(34);
        Reset = 1'b1;
        plan_st = 2'd0;
        push(cyc + 1, K_ST, 2'd0);
        tick();
        Reset = 1'b0;
        idle(20);
        btn_up = 1'b0;
        idle(10);
        hold(1'b1, 1'b0, 8, 1'b0);
        idle(10);

        check({3'b0, q.size() == 0}, 4'd1, "queue_drained");
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, fails);
        $finish;
    end

endmodule
